// File: rtl/array_result_collector.sv
// array_result_collector
//   Drains the per-column output controllers of the systolic array in
//   column-major order (column 0 rows 0..ROWS-1, then column 1, ...) and
//   packs the words into a small FIFO. The FIFO head is presented as a
//   valid/ready stream with an end-of-tile marker.
//
//   Optional build macro: COLLECT_TAG_EN adds m_col/m_row origin tags
//   to every FIFO entry and drives them alongside m_data.
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset
//   col_r      head result of each column; column c occupies
//              col_r[c*OUTWIDTH +: OUTWIDTH]
//   col_v      head valid, bit c for column c
//   col_rread  one-cycle read strobe, bit c for column c
//   m_data     stream data (FIFO head)
//   m_valid    stream valid
//   m_ready    stream ready
//   m_last     final result of a tile (col COLS-1, row ROWS-1)
//   busy       tile in progress
//   m_col      (COLLECT_TAG_EN) source column of m_data
//   m_row      (COLLECT_TAG_EN) source row of m_data
module array_result_collector #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int OUTWIDTH   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [COLS*OUTWIDTH-1:0] col_r,
  input  logic [COLS-1:0]          col_v,
  output logic [COLS-1:0]          col_rread,
  output logic [OUTWIDTH-1:0]      m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy
`ifdef COLLECT_TAG_EN
  ,
  output logic [$clog2(COLS)-1:0]  m_col,
  output logic [$clog2(ROWS)-1:0]  m_row
`endif
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  logic [CW-1:0]       r_cur_col;
  logic [RW-1:0]       r_row_cnt;
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [NW-1:0]       r_count;
  logic                r_busy;
  logic [OUTWIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                r_mem_last [FIFO_DEPTH];
`ifdef COLLECT_TAG_EN
  logic [CW-1:0]       r_mem_col  [FIFO_DEPTH];
  logic [RW-1:0]       r_mem_row  [FIFO_DEPTH];
`endif

  logic [OUTWIDTH-1:0] w_col_word [COLS];
  logic                w_full;
  logic                w_take;
  logic                w_pop;
  logic                w_tile_end;
  logic                w_tile_start;

  for (genvar g = 0; g < COLS; g++) begin : g_split
    assign w_col_word[g] = col_r[g*OUTWIDTH +: OUTWIDTH];
  end

  // A full FIFO blocks the push even when a pop happens in the same cycle.
  assign w_full       = (r_count == NW'(FIFO_DEPTH));
  // Strobes are suppressed while reset is asserted.
  assign w_take       = rstn && col_v[r_cur_col] && !w_full;
  assign w_pop        = m_valid && m_ready;
  assign w_tile_end   = (r_cur_col == CW'(COLS-1)) && (r_row_cnt == RW'(ROWS-1));
  assign w_tile_start = (r_cur_col == '0) && (r_row_cnt == '0);

  always_comb begin
    col_rread            = '0;
    col_rread[r_cur_col] = w_take;
  end

  // Storage is cleared on reset so the head reads back as zero.
  assign m_valid = (r_count != '0);
  assign m_data  = r_mem_data[r_rptr];
  assign m_last  = r_mem_last[r_rptr];
  assign busy    = r_busy;
`ifdef COLLECT_TAG_EN
  assign m_col   = r_mem_col[r_rptr];
  assign m_row   = r_mem_row[r_rptr];
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cur_col <= '0;
      r_row_cnt <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_last[i] <= 1'b0;
`ifdef COLLECT_TAG_EN
        r_mem_col[i]  <= '0;
        r_mem_row[i]  <= '0;
`endif
      end
    end else begin
      if (w_take) begin
        r_mem_data[r_wptr] <= w_col_word[r_cur_col];
        r_mem_last[r_wptr] <= w_tile_end;
`ifdef COLLECT_TAG_EN
        r_mem_col[r_wptr]  <= r_cur_col;
        r_mem_row[r_wptr]  <= r_row_cnt;
`endif
        r_wptr    <= r_wptr + 1'b1;
        r_row_cnt <= r_row_cnt + 1'b1;
        if (r_row_cnt == RW'(ROWS-1)) begin
          r_cur_col <= r_cur_col + 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_take, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Start of a new tile takes priority over the end of the previous one.
      if (w_pop && m_last) begin
        r_busy <= 1'b0;
      end
      if (w_take && w_tile_start) begin
        r_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_array_result_collector.sv
module tb_array_result_collector;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int OW    = 32;
  localparam int DEPTH = 4;
  localparam int TILE  = ROWS * COLS;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [COLS*OW-1:0] col_r = '0;
  logic [COLS-1:0]    col_v = '0;
  logic [COLS-1:0]    col_rread;
  logic [OW-1:0]      m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               m_last;
  logic               busy;
`ifdef COLLECT_TAG_EN
  logic [2:0]         m_col;
  logic [2:0]         m_row;
`endif

  array_result_collector #(
    .ROWS(ROWS), .COLS(COLS), .OUTWIDTH(OW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .col_r(col_r), .col_v(col_v), .col_rread(col_rread),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy)
`ifdef COLLECT_TAG_EN
    , .m_col(m_col), .m_row(m_row)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
    int            c;
    int            r;
  } entry_t;

  // Reference model: upstream column heads, expected word order, FIFO queue.
  logic [OW-1:0] tiledata [COLS][ROWS];
  int            head [COLS];
  entry_t        q [$];
  int            n_taken = 0;
  logic          busy_m = 1'b0;
  logic          after_rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int pops = 0;
  int lasts = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rn, input logic [COLS-1:0] v, input logic rdy);
    int            ec;
    int            er;
    logic          et;
    logic          pop;
    logic [COLS-1:0] exp_rd;
    entry_t        e;
    @(negedge clk);
    rstn    = rn;
    col_v   = v;
    m_ready = rdy;
    for (int c = 0; c < COLS; c++) col_r[c*OW +: OW] = tiledata[c][head[c]];
    #1;
    ec = (n_taken / ROWS) % COLS;
    er = n_taken % ROWS;
    et = rn && v[ec] && (q.size() < DEPTH);
    exp_rd = '0;
    if (et) exp_rd[ec] = 1'b1;
    chk("col_rread", col_rread, exp_rd);
    chk("m_valid", m_valid, q.size() != 0);
    chk("busy", busy, busy_m);
    if (q.size() != 0) begin
      chk("m_data", m_data, q[0].d);
      chk("m_last", m_last, q[0].l);
`ifdef COLLECT_TAG_EN
      chk("m_col", m_col, q[0].c);
      chk("m_row", m_row, q[0].r);
`endif
    end else if (after_rst) begin
      chk("m_data_rst", m_data, 0);
      chk("m_last_rst", m_last, 0);
    end
    strobes += $countones(col_rread);
    if (m_valid && rdy) begin
      pops++;
      if (m_last) lasts++;
    end
    pop = (q.size() != 0) && rdy;
    @(posedge clk);
    if (!rn) begin
      q.delete();
      n_taken   = 0;
      busy_m    = 1'b0;
      after_rst = 1'b1;
      for (int c = 0; c < COLS; c++) head[c] = 0;
    end else begin
      after_rst = 1'b0;
      if (pop) begin
        e = q.pop_front();
        if (e.l) busy_m = 1'b0;
      end
      if (et) begin
        q.push_back('{tiledata[ec][head[ec]], n_taken == TILE-1, ec, er});
        if (n_taken == 0) busy_m = 1'b1;
        head[ec] = (head[ec] + 1) % ROWS;
        n_taken  = (n_taken + 1) % TILE;
      end
    end
  endtask

  // Completes the current tile and drains the FIFO without starting another.
  task automatic finish_tile(input logic [COLS-1:0] v);
    for (int i = 0; i < 400; i++) begin
      if (n_taken == 0 && q.size() == 0) break;
      cyc(1'b1, (n_taken == 0) ? '0 : v, 1'b1);
    end
  endtask

  task automatic randomize_data();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) tiledata[c][r] = $urandom;
  endtask

  initial begin
    for (int c = 0; c < COLS; c++) begin
      head[c] = 0;
      for (int r = 0; r < ROWS; r++) tiledata[c][r] = c*16 + r;
    end

    // Reset held with every column valid.
    for (int i = 0; i < 3; i++) cyc(1'b0, '1, 1'b1);

    // Full tile, col*16+row data, ready always high.
    pops = 0; lasts = 0;
    for (int i = 0; i < TILE; i++) cyc(1'b1, '1, 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, '0, 1'b1);
    chk("tile_pops", pops, TILE);
    chk("tile_lasts", lasts, 1);

    // Backpressure: only FIFO_DEPTH strobes, head holds the row-0 word.
    randomize_data();
    strobes = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, '1, 1'b0);
    chk("bp_strobes", strobes, DEPTH);
    chk("bp_hold", m_data, tiledata[0][0]);
    finish_tile('1);

    // Gap in column 2 while column 3 is valid.
    randomize_data();
    for (int i = 0; i < 100 && n_taken != 2*ROWS; i++) cyc(1'b1, '1, 1'b1);
    strobes = 0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'hFB, 1'b1);
    chk("gap_strobes", strobes, 0);
    finish_tile('1);

    // Mid-tile reset after 13 words.
    randomize_data();
    for (int i = 0; i < 100 && n_taken != 13; i++) cyc(1'b1, '1, 1'b1);
    cyc(1'b0, '1, 1'b1);
    cyc(1'b1, '1, 1'b1);
    finish_tile('1);

    // Randomized valid and ready.
    randomize_data();
    for (int i = 0; i < 600; i++) cyc(1'b1, COLS'($urandom | $urandom), $urandom_range(0, 3) != 0);
    finish_tile('1);
    cyc(1'b1, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
